mem_port_arbiter: RTL

Arbitrates the single-port, 1-cycle-latency instruction/data RAM among the pipelined CPU's three memory requesters: instruction fetch, load read and store write. Sits between the CPU memory pins and the RAM macro. Uses fixed priority (store > load > fetch) with a fetch anti-starvation boost. Per-requester stall lets the pipeline hold a request until it is granted, and read data is routed back to the issuing requester.

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter for fetch / load / store with fixed priority
// (store > load > fetch), a fetch anti-starvation boost and tagged read return.
module mem_port_arbiter #(
   parameter int ADRS_W   = 11,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 3,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ir_req,
   input  logic [ADRS_W-1:0] ir_adrs,
   output logic              ir_stall,
   output logic              ir_rvalid,
   output logic [DATA_W-1:0] ir_rdata,
   input  logic              ld_req,
   input  logic [ADRS_W-1:0] ld_adrs,
   output logic              ld_stall,
   output logic              ld_rvalid,
   output logic [DATA_W-1:0] ld_rdata,
   input  logic              st_req,
   input  logic [ADRS_W-1:0] st_adrs,
   input  logic [DATA_W-1:0] st_wdata,
   output logic              st_stall,
   output logic              ram_en,
   output logic              ram_we,
   output logic [ADRS_W-1:0] ram_adrs,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic              cnt_clr,
   output logic [CNT_W-1:0]  conflict_cnt
);

   localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

   localparam logic [1:0] TAG_NONE = 2'd0;
   localparam logic [1:0] TAG_IR   = 2'd1;
   localparam logic [1:0] TAG_LD   = 2'd2;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [WAIT_W-1:0] ir_wait;
   logic [1:0]        tag_p1;
   logic [DATA_W-1:0] ir_hold;
   logic [DATA_W-1:0] ld_hold;
   logic              boost;
   logic              gnt_ir;
   logic              gnt_ld;
   logic              gnt_st;
   logic [1:0]        n_req;
   logic              conflict;

   // Stage p0: combinational arbitration; boost overrides fixed priority.
   assign boost  = ir_req && (ir_wait == WAIT_LIM);
   assign gnt_st = !reset && st_req && !boost;
   assign gnt_ld = !reset && ld_req && !st_req && !boost;
   assign gnt_ir = !reset && ir_req && (boost || (!st_req && !ld_req));

   assign ir_stall = ir_req & ~gnt_ir;
   assign ld_stall = ld_req & ~gnt_ld;
   assign st_stall = st_req & ~gnt_st;

   assign n_req    = 2'(ir_req) + 2'(ld_req) + 2'(st_req);
   assign conflict = (n_req >= 2'd2);

   always_comb begin
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_adrs  = '0;
      ram_wdata = '0;
      if (gnt_st) begin
         ram_en    = 1'b1;
         ram_we    = 1'b1;
         ram_adrs  = st_adrs;
         ram_wdata = st_wdata;
      end else if (gnt_ld) begin
         ram_en   = 1'b1;
         ram_adrs = ld_adrs;
      end else if (gnt_ir) begin
         ram_en   = 1'b1;
         ram_adrs = ir_adrs;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ir_wait      <= '0;
         tag_p1       <= TAG_NONE;
         conflict_cnt <= '0;
      end else begin
         if (!ir_req || gnt_ir)
            ir_wait <= '0;
         else if (ir_wait != WAIT_LIM)
            ir_wait <= ir_wait + 1'b1;

         if (gnt_ir)
            tag_p1 <= TAG_IR;
         else if (gnt_ld)
            tag_p1 <= TAG_LD;
         else
            tag_p1 <= TAG_NONE;

         if (cnt_clr)
            conflict_cnt <= '0;
         else if (conflict)
            conflict_cnt <= sat_inc(conflict_cnt);
      end
   end

   // Stage p1: RAM data returns; capture into the tagged requester's hold register.
   always_ff @(posedge clk) begin
      if (reset) begin
         ir_hold <= '0;
         ld_hold <= '0;
      end else begin
         if (tag_p1 == TAG_IR) ir_hold <= ram_rdata;
         if (tag_p1 == TAG_LD) ld_hold <= ram_rdata;
      end
   end

   assign ir_rvalid = !reset && (tag_p1 == TAG_IR);
   assign ld_rvalid = !reset && (tag_p1 == TAG_LD);
   assign ir_rdata  = reset ? '0 : (ir_rvalid ? ram_rdata : ir_hold);
   assign ld_rdata  = reset ? '0 : (ld_rvalid ? ram_rdata : ld_hold);

endmodule
